pipe_io_responder: RTL and testbench
====================================

Name: pipe_io_responder

Overview:
- Memory-mapped I/O responder on the CPU's MEM-stage data bus. It is the device end of the accesses the pipeline initiates.
- Conditions the two 4-bit switch inputs with a synchronizer and a debouncer, and latches change flags.
- Holds the 5-bit output port register that drives the 7-segment/BCD path.
- Answers bus reads and writes by address decode.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its stable value before it is accepted. Legal range 1..255.
- IN1_ADDR, 32'h0000_0080: address of input port 1 (RO).
- IN2_ADDR, 32'h0000_0084: address of input port 2 (RO).
- STAT_ADDR, 32'h0000_0088: address of the change-flag register (RO, read-to-clear).
- OUT_ADDR, 32'h0000_00C0: address of the output port register (RW).

Ports:
- clock  in  1  system clock; all state changes on rising edge
- resetn  in  1  asynchronous active-low reset
- addr  in  32  bus address (malu)
- wdata  in  32  bus write data (mb)
- we  in  1  write strobe (mwmem)
- re  in  1  read strobe; qualifies read-to-clear side effects
- rdata  out  32  read data; combinational from registered state
- hit  out  1  addr matches one of the mapped addresses
- input_port1  in  4  raw switch bank 1, asynchronous
- input_port2  in  4  raw switch bank 2, asynchronous
- output_port  out  5  registered output value
- irq  out  1  interrupt request (see Optional Feature)

Behaviour:
- Reset, while resetn=0: sync flops, stable values, debounce counters, STAT, OUT and the mask are all cleared.
  - Resulting outputs: rdata=0, output_port=0, irq=0.
  - hit is combinational on addr.
  - Reset mid-debounce discards the pending change; no flag is set.
- Synchronizer: two flops per input bit, giving 4-bit sync1 and sync2.
- Debounce, per port independently:
  - If sync != stable, cnt increments; otherwise cnt is cleared to 0.
  - When cnt == DEBOUNCE_CYCLES-1 and sync != stable: on that edge stable<=sync, cnt<=0, and the port's change flag is set.
  - Latency from a raw input change to the new value being readable is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - The counter saturates and does not wrap; width is clog2(DEBOUNCE_CYCLES)+1.
- Address decode is an exact 32-bit compare; hit=1 on any of the 4 addresses.
- Read mux (rdata is 0 whenever hit=0):
  - IN1: {28'b0, stable1}
  - IN2: {28'b0, stable2}
  - STAT: {30'b0, chg2, chg1}
  - OUT: {27'b0, out_reg}
- Read-to-clear: on a rising edge with re=1 and addr==STAT_ADDR, both flags clear.
  - A flag being set on that same edge wins: it stays 1.
  - The read itself returns the pre-edge value.
- Writes: on a rising edge with we=1 and addr==OUT_ADDR, out_reg<=wdata[4:0]; wdata[31:5] is ignored.
  - Writes to RO or unmapped addresses have no effect.
  - Simultaneous re and we to OUT_ADDR: rdata shows the old value and the new value takes effect after the edge.
- output_port = out_reg; it changes only on the clock edge after a write.
- we and re are not required to be one-hot. Back-to-back accesses every cycle are supported, with no wait states.

Optional Feature:
- Macro: PIPE_IO_IRQ_EN.
- With the macro defined:
  - Adds a 2-bit mask register at STAT_ADDR+4 (RW, wdata[1:0], reset 0).
  - irq = |(mask & {chg2,chg1}), registered: asserts the cycle after a flag or mask bit sets.
  - irq drops the cycle after read-to-clear.
  - The decode includes the mask address in hit.
- Without the macro: irq is tied to 0, the mask address is unmapped, and there is no mask register.

Test Plan:
- Reset: hold resetn=0 with input_port1=4'hF and we=1 to OUT_ADDR -> output_port=0, rdata=0 and irq=0 throughout; after release, reading IN1 gives 0 until 2+16 cycles pass, then 32'h0000000F.
- Glitch: pulse input_port2 from 0 to 4'h5 for 15 cycles, then back to 0 -> IN2 reads 0 and STAT reads 0. Hold 4'h5 for 18 cycles -> IN2=32'h5 and STAT=32'h2.
- Read-to-clear race: with chg1 set, issue re to STAT on the same edge that a new port-1 value stabilizes -> this read returns 32'h1 and the next read still returns 32'h1. A further read after no change returns 0.
- Output write: we=1, addr=32'hC0, wdata=32'hFFFF_FFF7 -> output_port=5'h17 after the edge, and a read of OUT returns 32'h17. A write to 32'h80 with wdata=9 leaves IN1 and output_port unchanged.
- Decode: addr=32'h0000_0090 and addr=32'h1000_0080 -> hit=0 and rdata=0. addr=32'h84 -> hit=1.
- IRQ (macro on): write mask=2'b01, stabilize input_port1 to 4'h3 -> irq=1 one cycle after chg1 sets; read STAT -> irq=0 the following cycle. A port-2 change with mask bit1=0 leaves irq=0.

Source files
------------

// File: rtl/pipe_io_responder_if.sv
// Data-bus bundle between the MEM stage (master) and the I/O responder (slave).
// Purely combinational wiring; no latency of its own.
// No stall signal: the slave answers every access in the same cycle.
interface pipe_io_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        hit;

  modport master (output addr, output wdata, output we, output re,
                  input rdata, input hit);
  modport slave  (input addr, input wdata, input we, input re,
                  output rdata, output hit);
endinterface

// File: rtl/pipe_io_responder.sv
// Memory-mapped I/O responder: debounced switch inputs, change flags, output port register.
// Reads are combinational from registered state; writes land on the next rising edge.
// Never stalls; accesses may arrive every cycle. Optional irq/mask logic: define PIPE_IO_IRQ_EN.
module pipe_io_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] IN1_ADDR  = 32'h0000_0080,
  parameter logic [31:0] IN2_ADDR  = 32'h0000_0084,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0088,
  parameter logic [31:0] OUT_ADDR  = 32'h0000_00C0
) (
  input  logic                 clock,
  input  logic                 resetn,
  pipe_io_responder_if.slave   bus,
  input  logic [3:0]           input_port1,
  input  logic [3:0]           input_port2,
  output logic [4:0]           output_port,
  output logic                 irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Index 0 is port 1, index 1 is port 2.
  logic [1:0][3:0]    meta_q, meta_d;
  logic [1:0][3:0]    sync_q, sync_d;
  logic [1:0][3:0]    stable_q, stable_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         chg_q, chg_d;
  logic [1:0]         chg_set;
  logic [4:0]         out_q, out_d;
  logic [1:0][3:0]    raw;

  logic sel_in1, sel_in2, sel_stat, sel_out, sel_mask;
  logic [31:0] rdata_c;

  // Only the low bits of write data are ever stored.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:5];

  assign raw[0] = input_port1;
  assign raw[1] = input_port2;

  assign sel_in1  = (bus.addr == IN1_ADDR);
  assign sel_in2  = (bus.addr == IN2_ADDR);
  assign sel_stat = (bus.addr == STAT_ADDR);
  assign sel_out  = (bus.addr == OUT_ADDR);

`ifdef PIPE_IO_IRQ_EN
  localparam logic [31:0] MASK_ADDR = STAT_ADDR + 32'd4;
  logic [1:0] mask_q, mask_d;
  logic       irq_q, irq_d;

  assign sel_mask = (bus.addr == MASK_ADDR);

  // Mask register write and registered interrupt from currently pending flags.
  always_comb begin
    mask_d = mask_q;
    if (bus.we && sel_mask) mask_d = bus.wdata[1:0];
    irq_d = |(mask_q & chg_q);
  end

  // Mask and irq state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign sel_mask = 1'b0;
  assign irq      = 1'b0;
`endif

  // Two-flop synchronizer followed by a per-port saturating debounce counter.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      meta_d[p]   = raw[p];
      sync_d[p]   = meta_q[p];
      stable_d[p] = stable_q[p];
      cnt_d[p]    = '0;
      chg_set[p]  = 1'b0;
      if (sync_q[p] != stable_q[p]) begin
        if (cnt_q[p] == CNT_LAST) begin
          stable_d[p] = sync_q[p];
          chg_set[p]  = 1'b1;
        end else if (cnt_q[p] < CNT_LAST) begin
          cnt_d[p] = cnt_q[p] + CW'(1);
        end else begin
          cnt_d[p] = cnt_q[p];
        end
      end
    end
  end

  // Change flags clear on a STAT read, but a flag raised on the same edge survives.
  always_comb begin
    chg_d = chg_q;
    if (bus.re && sel_stat) chg_d = 2'b00;
    chg_d = chg_d | chg_set;
  end

  // Output port register write.
  always_comb begin
    out_d = out_q;
    if (bus.we && sel_out) out_d = bus.wdata[4:0];
  end

  // Read mux; zero whenever nothing is selected.
  always_comb begin
    rdata_c = '0;
    if (sel_in1)  rdata_c = {28'b0, stable_q[0]};
    if (sel_in2)  rdata_c = {28'b0, stable_q[1]};
    if (sel_stat) rdata_c = {30'b0, chg_q};
    if (sel_out)  rdata_c = {27'b0, out_q};
`ifdef PIPE_IO_IRQ_EN
    if (sel_mask) rdata_c = {30'b0, mask_q};
`endif
  end

  // Core register state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      chg_q    <= '0;
      out_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      out_q    <= out_d;
    end
  end

  assign bus.rdata   = rdata_c;
  assign bus.hit     = sel_in1 | sel_in2 | sel_stat | sel_out | sel_mask;
  assign output_port = out_q;

endmodule

// File: tb/tb_pipe_io_responder.sv
// Bench for pipe_io_responder: directed steps from the test plan, then random traffic.
// A behavioural model tracks accepted switch values, flags, output and mask.
// Honours PIPE_IO_IRQ_EN the same way as the design.
`timescale 1ns/1ps
module tb_pipe_io_responder;
  localparam int D = 16;
  localparam logic [31:0] A_IN1  = 32'h0000_0080;
  localparam logic [31:0] A_IN2  = 32'h0000_0084;
  localparam logic [31:0] A_STAT = 32'h0000_0088;
  localparam logic [31:0] A_MASK = 32'h0000_008C;
  localparam logic [31:0] A_OUT  = 32'h0000_00C0;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] input_port1 = 4'h0;
  logic [3:0] input_port2 = 4'h0;
  logic [4:0] output_port;
  logic       irq;

  pipe_io_responder_if bus();

  pipe_io_responder dut (
    .clock(clock), .resetn(resetn), .bus(bus.slave),
    .input_port1(input_port1), .input_port2(input_port2),
    .output_port(output_port), .irq(irq)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model: s1/s2 are the raw values one and two edges late, run counts edges
  // on which the delayed value disagreed with the accepted one.
  int m_s1[2], m_s2[2], m_stable[2], m_run[2];
  bit m_chg[2];
  int m_out, m_mask;
  bit m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    bit h;
    h = (a == A_IN1) || (a == A_IN2) || (a == A_STAT) || (a == A_OUT);
`ifdef PIPE_IO_IRQ_EN
    h = h || (a == A_MASK);
`endif
    return h;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    if (a == A_IN1)  return 32'(m_stable[0]);
    if (a == A_IN2)  return 32'(m_stable[1]);
    if (a == A_STAT) return {30'b0, m_chg[1], m_chg[0]};
    if (a == A_OUT)  return 32'(m_out);
`ifdef PIPE_IO_IRQ_EN
    if (a == A_MASK) return 32'(m_mask);
`endif
    return 32'h0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_hit"},   32'(bus.hit),     32'(m_hit(bus.addr)));
    chk({tag, "_rdata"}, bus.rdata,        m_rdata(bus.addr));
    chk({tag, "_out"},   32'(output_port), 32'(m_out));
    chk({tag, "_irq"},   32'(irq),         32'(m_irq));
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_s1[p] = 0; m_s2[p] = 0; m_stable[p] = 0; m_run[p] = 0; m_chg[p] = 0;
    end
    m_out = 0; m_mask = 0; m_irq = 0;
  endtask

  // Advance one clock: model consumes the pre-edge inputs, then DUT is compared.
  task automatic tick(input string tag);
    int raw[2];
    bit set[2];
    bit clr;
    bit nxt_irq;
    raw[0] = int'(input_port1);
    raw[1] = int'(input_port2);
    clr = bus.re && (bus.addr == A_STAT);
    nxt_irq = ((m_mask & ((m_chg[1] ? 2 : 0) | (m_chg[0] ? 1 : 0))) != 0);
    for (int p = 0; p < 2; p++) begin
      set[p] = 0;
      if (m_s2[p] != m_stable[p]) begin
        m_run[p]++;
        if (m_run[p] == D) begin
          m_stable[p] = m_s2[p];
          m_run[p] = 0;
          set[p] = 1;
        end
      end else begin
        m_run[p] = 0;
      end
      m_s2[p] = m_s1[p];
      m_s1[p] = raw[p];
      if (clr) m_chg[p] = 0;
      if (set[p]) m_chg[p] = 1;
    end
    if (bus.we && bus.addr == A_OUT) m_out = int'(bus.wdata[4:0]);
`ifdef PIPE_IO_IRQ_EN
    if (bus.we && bus.addr == A_MASK) m_mask = int'(bus.wdata[1:0]);
`endif
    m_irq = nxt_irq;
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic bus_set(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
    bus.addr = a; bus.we = w; bus.re = r; bus.wdata = d;
    #1;
  endtask

  initial begin
    model_reset();
    // Reset held with live inputs and a write in flight.
    input_port1 = 4'hF;
    bus.addr = A_OUT; bus.we = 1'b1; bus.re = 1'b0; bus.wdata = 32'h0000_001F;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk("rst_out",   32'(output_port), 32'h0);
      chk("rst_rdata", bus.rdata,        32'h0);
      chk("rst_irq",   32'(irq),         32'h0);
    end
    resetn = 1'b1;
    bus_set(A_IN1, 1'b0, 1'b0, 32'h0);
    check_all("rel");
    ticks(2 + D - 1, "in1_wait");
    chk("in1_before", bus.rdata, 32'h0);
    tick("in1_edge");
    chk("in1_after", bus.rdata, 32'h0000_000F);

    // Clear the flag raised by port 1, then a 15-cycle glitch on port 2.
    bus_set(A_STAT, 1'b0, 1'b1, 32'h0);
    chk("stat_first", bus.rdata, 32'h1);
    tick("stat_clr");
    bus_set(A_IN2, 1'b0, 1'b0, 32'h0);
    input_port2 = 4'h5;
    ticks(15, "glitch_hi");
    input_port2 = 4'h0;
    ticks(20, "glitch_lo");
    chk("glitch_in2", bus.rdata, 32'h0);
    bus_set(A_STAT, 1'b0, 1'b0, 32'h0);
    chk("glitch_stat", bus.rdata, 32'h0);
    input_port2 = 4'h5;
    ticks(2 + D, "in2_hold");
    chk("hold_stat", bus.rdata, 32'h2);
    bus_set(A_IN2, 1'b0, 1'b0, 32'h0);
    chk("hold_in2", bus.rdata, 32'h5);
    bus_set(A_STAT, 1'b0, 1'b1, 32'h0);
    tick("stat_clr2");

    // Read-to-clear racing a new port-1 value.
    bus_set(A_IN1, 1'b0, 1'b0, 32'h0);
    input_port1 = 4'h3;
    ticks(2 + D, "p1_set");
    input_port1 = 4'h7;
    ticks(2 + D - 1, "p1_race_wait");
    bus_set(A_STAT, 1'b0, 1'b1, 32'h0);
    chk("race_read1", bus.rdata, 32'h1);
    tick("race_edge");
    chk("race_read2", bus.rdata, 32'h1);
    tick("race_clr");
    chk("race_read3", bus.rdata, 32'h0);

    // Output register writes, including a write to a read-only address.
    bus_set(A_OUT, 1'b1, 1'b0, 32'hFFFF_FFF7);
    chk("out_pre", 32'(output_port), 32'h0);
    tick("out_wr");
    chk("out_port", 32'(output_port), 32'h17);
    bus_set(A_OUT, 1'b0, 1'b0, 32'h0);
    chk("out_read", bus.rdata, 32'h17);
    bus_set(A_IN1, 1'b1, 1'b0, 32'h9);
    tick("ro_wr");
    chk("ro_in1", bus.rdata, 32'h7);
    chk("ro_out", 32'(output_port), 32'h17);
    bus_set(A_OUT, 1'b1, 1'b1, 32'h3);
    chk("rw_old", bus.rdata, 32'h17);
    tick("rw_edge");
    chk("rw_new", bus.rdata, 32'h3);

    // Address decode.
    bus_set(32'h0000_0090, 1'b0, 1'b0, 32'h0);
    chk("dec90_hit", 32'(bus.hit), 32'h0);
    chk("dec90_rd",  bus.rdata,    32'h0);
    bus_set(32'h1000_0080, 1'b0, 1'b0, 32'h0);
    chk("dechi_hit", 32'(bus.hit), 32'h0);
    chk("dechi_rd",  bus.rdata,    32'h0);
    bus_set(A_IN2, 1'b0, 1'b0, 32'h0);
    chk("dec84_hit", 32'(bus.hit), 32'h1);
    bus_set(A_MASK, 1'b0, 1'b0, 32'h0);
    check_all("dec_mask");

`ifdef PIPE_IO_IRQ_EN
    // Interrupt path with only bit 0 unmasked.
    bus_set(A_MASK, 1'b1, 1'b0, 32'h1);
    tick("mask_wr");
    bus_set(A_IN1, 1'b0, 1'b0, 32'h0);
    input_port1 = 4'h3;
    ticks(2 + D, "irq_wait");
    chk("irq_flag_edge", 32'(irq), 32'h0);
    tick("irq_rise");
    chk("irq_high", 32'(irq), 32'h1);
    bus_set(A_STAT, 1'b0, 1'b1, 32'h0);
    tick("irq_clr");
    bus_set(A_IN1, 1'b0, 1'b0, 32'h0);
    tick("irq_fall");
    chk("irq_low", 32'(irq), 32'h0);
    input_port2 = 4'hA;
    ticks(2 + D + 2, "irq_p2");
    chk("irq_masked", 32'(irq), 32'h0);
`endif

    // Random traffic: sparse switch changes, mixed reads/writes every cycle.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] a;
      case ($urandom_range(6))
        0: a = A_IN1;
        1: a = A_IN2;
        2: a = A_STAT;
        3: a = A_MASK;
        4: a = A_OUT;
        5: a = 32'h0000_0090;
        default: a = $urandom;
      endcase
      if ($urandom_range(24) == 0) input_port1 = 4'($urandom);
      if ($urandom_range(24) == 0) input_port2 = 4'($urandom);
      bus_set(a, 1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0), $urandom);
      check_all("rnd_pre");
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
